// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU fetch stage.
//  - RESET_VECTOR_DEFAULT / HALT_ADDRESS_DEFAULT : default PC after reset / halting fetch address
//  - fetch_state_t  : fetch controller states
//  - fetch_bundle_t : {instruction, address+4} pair carried by the skid and output registers
package mips_cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] INSTR_BYTES = WORD_W'(4);

    localparam logic [WORD_W-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [WORD_W-1:0] HALT_ADDRESS_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_READ,
        FETCH_SKID,
        FETCH_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus_four;
    } fetch_bundle_t;

    // Sequential instruction address; wraps mod 2^32.
    function automatic logic [WORD_W-1:0] word_increment(input logic [WORD_W-1:0] addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/program_counter_register.sv
// Program counter with delay-slot redirect latch.
// Ports:
//  clk, reset                   clock / async active-high reset
//  accept                       current fetch accepted this cycle; pc advances
//  redirect_valid/_target       redirect pulse from decode and its target
//  pc                           current fetch address (registered)
//  pc_plus_four_c               pc + 4 (combinational)
//  pc_accept_next_c             value pc takes if accept is high (combinational)
module program_counter_register
    import mips_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus_four_c,
    output logic [WORD_W-1:0] pc_accept_next_c
);

    logic              redirect_pending;
    logic [WORD_W-1:0] redirect_target_q;

    assign pc_plus_four_c = word_increment(pc);

    // A redirect arriving with the accept is newer than any pending one.
    always_comb begin
        pc_accept_next_c = pc_plus_four_c;
        if (redirect_valid) begin
            pc_accept_next_c = redirect_target;
        end else if (redirect_pending) begin
            pc_accept_next_c = redirect_target_q;
        end
    end

    // The fetch in flight is the delay slot: redirects only take effect once it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                <= RESET_VECTOR;
            redirect_pending  <= 1'b0;
            redirect_target_q <= '0;
        end else if (accept) begin
            pc               <= pc_accept_next_c;
            redirect_pending <= 1'b0;
        end else if (redirect_valid) begin
            redirect_pending  <= 1'b1;
            redirect_target_q <= redirect_target;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline.
// Ports:
//  clk, reset                          clock / async active-high reset
//  stall_fetch                         hold the fetch output register this cycle
//  redirect_valid, redirect_target     taken branch/jump from decode (applies after delay slot)
//  imem_address, imem_read             instruction memory read request (address = pc)
//  imem_waitrequest, imem_readdata     memory handshake and returned word
//  instruction_fetch                   instruction to F/D register (0 when invalid)
//  program_counter_plus_four_fetch     address of instruction_fetch + 4
//  fetch_valid                         instruction_fetch holds a real instruction
//  HALT_fetch                          sticky: fetch reached HALT_ADDRESS and drained
module instruction_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [WORD_W-1:0] HALT_ADDRESS = HALT_ADDRESS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_fetch,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] imem_address,
    output logic              imem_read,
    input  logic              imem_waitrequest,
    input  logic [WORD_W-1:0] imem_readdata,
    output logic [WORD_W-1:0] instruction_fetch,
    output logic [WORD_W-1:0] program_counter_plus_four_fetch,
    output logic              fetch_valid,
    output logic              HALT_fetch
);

    fetch_state_t      state;
    fetch_state_t      state_next;

    fetch_bundle_t     out_q;
    fetch_bundle_t     out_d;
    fetch_bundle_t     skid_q;
    fetch_bundle_t     skid_d;
    logic              skid_valid_q;
    logic              skid_valid_d;
    logic              valid_d;
    logic              halt_d;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus_four_c;
    logic [WORD_W-1:0] pc_accept_next_c;

    logic              accept_c;
    logic              out_free_c;
    logic              halt_on_accept_c;
    fetch_bundle_t     fetched_c;

    assign accept_c         = imem_read & ~imem_waitrequest;
    assign out_free_c       = ~stall_fetch | ~fetch_valid;
    assign halt_on_accept_c = (pc_accept_next_c == HALT_ADDRESS);
    assign fetched_c        = '{instr: imem_readdata, pc_plus_four: pc_plus_four_c};

    program_counter_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk              (clk),
        .reset            (reset),
        .accept           (accept_c),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .pc               (pc),
        .pc_plus_four_c   (pc_plus_four_c),
        .pc_accept_next_c (pc_accept_next_c)
    );

    assign imem_address                    = pc;
    assign instruction_fetch               = out_q.instr;
    assign program_counter_plus_four_fetch = out_q.pc_plus_four;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: begin
                if (pc == HALT_ADDRESS) begin
                    state_next = FETCH_HALTED;
                end else if (out_free_c) begin
                    state_next = FETCH_READ;
                end
            end
            FETCH_READ: begin
                // Stall in the accept cycle parks the word in the skid.
                if (accept_c) begin
                    if (halt_on_accept_c) begin
                        state_next = FETCH_HALTED;
                    end else if (out_free_c) begin
                        state_next = FETCH_READ;
                    end else begin
                        state_next = FETCH_SKID;
                    end
                end
            end
            FETCH_SKID: begin
                if (!stall_fetch) begin
                    state_next = FETCH_IDLE;
                end
            end
            FETCH_HALTED: begin
                state_next = FETCH_HALTED;
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // Output/skid register next values.
    always_comb begin
        out_d        = out_q;
        valid_d      = fetch_valid;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        halt_d       = HALT_fetch;
        case (state)
            FETCH_READ: begin
                if (accept_c) begin
                    if (out_free_c) begin
                        out_d   = fetched_c;
                        valid_d = 1'b1;
                    end else begin
                        skid_d       = fetched_c;
                        skid_valid_d = 1'b1;
                    end
                end else if (out_free_c) begin
                    out_d   = '0;
                    valid_d = 1'b0;
                end
            end
            FETCH_SKID: begin
                if (!stall_fetch) begin
                    out_d        = skid_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end
            FETCH_HALTED: begin
                // Drain any skid word first; HALT rises with the first empty output.
                if (out_free_c) begin
                    if (skid_valid_q) begin
                        out_d        = skid_q;
                        valid_d      = 1'b1;
                        skid_valid_d = 1'b0;
                    end else begin
                        out_d   = '0;
                        valid_d = 1'b0;
                        halt_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (out_free_c) begin
                    out_d   = '0;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    // Output, skid and read-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            fetch_valid  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            HALT_fetch   <= 1'b0;
            imem_read    <= 1'b0;
        end else begin
            out_q        <= out_d;
            fetch_valid  <= valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            HALT_fetch   <= halt_d;
            imem_read    <= (state_next == FETCH_READ);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    localparam logic [31:0] A = 32'hBFC0_0000;

    logic        clk;
    logic        reset;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;
    logic [31:0] instruction_fetch;
    logic [31:0] program_counter_plus_four_fetch;
    logic        fetch_valid;
    logic        HALT_fetch;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        wreq;
        logic [31:0] e_addr;
        logic        e_read;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_unit dut (
        .clk                             (clk),
        .reset                           (reset),
        .stall_fetch                     (stall_fetch),
        .redirect_valid                  (redirect_valid),
        .redirect_target                 (redirect_target),
        .imem_address                    (imem_address),
        .imem_read                       (imem_read),
        .imem_waitrequest                (imem_waitrequest),
        .imem_readdata                   (imem_readdata),
        .instruction_fetch               (instruction_fetch),
        .program_counter_plus_four_fetch (program_counter_plus_four_fetch),
        .fetch_valid                     (fetch_valid),
        .HALT_fetch                      (HALT_fetch)
    );

    // Memory model: every address holds a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_readdata = mem_word(imem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    function automatic void add(input logic s, input logic r, input logic [31:0] t, input logic w,
                                input logic [31:0] addr, input logic rd, input logic v,
                                input logic [31:0] ins, input logic [31:0] p4, input logic h);
        vec_t x;
        x.stall = s; x.redir = r; x.tgt = t; x.wreq = w;
        x.e_addr = addr; x.e_read = rd; x.e_valid = v;
        x.e_instr = ins; x.e_pc4 = p4; x.e_halt = h;
        vecs.push_back(x);
    endfunction

    task automatic check_outputs(input string tag, input int row, input logic [31:0] addr,
                                 input logic rd, input logic v, input logic [31:0] ins,
                                 input logic [31:0] p4, input logic h);
        chk({tag, ".addr"},  row, imem_address, addr);
        chk({tag, ".read"},  row, {31'b0, imem_read}, {31'b0, rd});
        chk({tag, ".valid"}, row, {31'b0, fetch_valid}, {31'b0, v});
        chk({tag, ".instr"}, row, instruction_fetch, ins);
        chk({tag, ".pc4"},   row, program_counter_plus_four_fetch, p4);
        chk({tag, ".halt"},  row, {31'b0, HALT_fetch}, {31'b0, h});
    endtask

    // Called at a falling edge: each row drives its inputs, checks, then advances one cycle.
    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            stall_fetch      = vecs[i].stall;
            redirect_valid   = vecs[i].redir;
            redirect_target  = vecs[i].tgt;
            imem_waitrequest = vecs[i].wreq;
            check_outputs(tag, i, vecs[i].e_addr, vecs[i].e_read, vecs[i].e_valid,
                          vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_halt);
            @(negedge clk);
        end
        stall_fetch      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_target  = '0;
        imem_waitrequest = 1'b0;
        vecs.delete();
    endtask

    initial begin
        reset            = 1'b1;
        stall_fetch      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_target  = '0;
        imem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Streaming, wait states, stall into skid, redirect delay slot, redirect to halt.
        //   s  r  tgt       w  addr       rd v  instr                p4         h
        add(0, 0, 0,        0, A,         0, 0, 0,                   0,         0);
        add(0, 0, 0,        0, A,         1, 0, 0,                   0,         0);
        add(0, 0, 0,        0, A+4,       1, 1, mem_word(A),         A+4,       0);
        add(0, 0, 0,        0, A+8,       1, 1, mem_word(A+4),       A+8,       0);
        add(0, 0, 0,        1, A+12,      1, 1, mem_word(A+8),       A+12,      0);
        add(1, 0, 0,        1, A+12,      1, 0, 0,                   0,         0);
        add(0, 0, 0,        1, A+12,      1, 0, 0,                   0,         0);
        add(0, 0, 0,        0, A+12,      1, 0, 0,                   0,         0);
        add(1, 0, 0,        0, A+16,      1, 1, mem_word(A+12),      A+16,      0);
        add(1, 0, 0,        0, A+20,      0, 1, mem_word(A+12),      A+16,      0);
        add(0, 0, 0,        0, A+20,      0, 1, mem_word(A+12),      A+16,      0);
        add(0, 0, 0,        0, A+20,      0, 1, mem_word(A+16),      A+20,      0);
        add(0, 1, A+32'h200,1, A+20,      1, 0, 0,                   0,         0);
        add(0, 1, A+32'h100,1, A+20,      1, 0, 0,                   0,         0);
        add(0, 0, 0,        0, A+20,      1, 0, 0,                   0,         0);
        add(0, 0, 0,        0, A+32'h100, 1, 1, mem_word(A+20),      A+24,      0);
        add(0, 1, 0,        0, A+32'h104, 1, 1, mem_word(A+32'h100), A+32'h104, 0);
        add(0, 0, 0,        0, 0,         0, 1, mem_word(A+32'h104), A+32'h108, 0);
        add(0, 0, 0,        0, 0,         0, 0, 0,                   0,         1);
        add(0, 0, 0,        0, 0,         0, 0, 0,                   0,         1);
        run_table("stream");

        // Async reset while halted: immediate return to reset values.
        chk("halt.pre", 0, {31'b0, HALT_fetch}, 32'd1);
        #2 reset = 1'b1;
        #1 check_outputs("rst_halt", 0, A, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Restart from the reset vector, then leave a read waiting.
        add(0, 0, 0, 0, A,   0, 0, 0,             0,   0);
        add(0, 0, 0, 0, A,   1, 0, 0,             0,   0);
        add(0, 0, 0, 0, A+4, 1, 1, mem_word(A),   A+4, 0);
        add(0, 0, 0, 1, A+8, 1, 1, mem_word(A+4), A+8, 0);
        add(0, 0, 0, 1, A+8, 1, 0, 0,             0,   0);
        run_table("restart");

        // Async reset mid-wait: read drops before the next clock edge.
        imem_waitrequest = 1'b1;
        #2 chk("wait.pre", 0, {31'b0, imem_read}, 32'd1);
        reset = 1'b1;
        #1 check_outputs("rst_wait", 0, A, 1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Redirect to the last word: pc+4 wraps to 0; stall on that accept exercises skid drain in HALTED.
        add(0, 0, 0,             0, A,             0, 0, 0,                      0,   0);
        add(0, 1, 32'hFFFF_FFFC, 1, A,             1, 0, 0,                      0,   0);
        add(0, 0, 0,             0, A,             1, 0, 0,                      0,   0);
        add(1, 0, 0,             0, 32'hFFFF_FFFC, 1, 1, mem_word(A),            A+4, 0);
        add(1, 0, 0,             0, 0,             0, 1, mem_word(A),            A+4, 0);
        add(0, 0, 0,             0, 0,             0, 1, mem_word(A),            A+4, 0);
        add(0, 0, 0,             0, 0,             0, 1, mem_word(32'hFFFF_FFFC), 0,  0);
        add(0, 0, 0,             0, 0,             0, 0, 0,                      0,   1);
        add(0, 0, 0,             0, 0,             0, 0, 0,                      0,   1);
        run_table("wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
